// File: rtl/led_bar_monitor.sv
// led_bar_monitor
//   Receive-side checker for a thermometer-coded LED bar. The LED bus is
//   registered once and then decoded to a bar level. A small FSM
//   (IDLE/RISE/FALL) follows the direction of travel, counts direction
//   reversals, captures the peak level, and flags illegal codes and steps.
//
// Ports
//   clk        rising-edge clock (same clock as the LED driver)
//   rst_n      asynchronous active-low reset
//   led_in     LED bus, thermometer code, bit 0 = first LED
//   clr        synchronous clear of the sticky errors and of peak
//   level      decoded bar level (number of lit LEDs)
//   dir        00 idle, 01 rising, 10 falling
//   turn       1-cycle pulse on each direction reversal
//   turn_cnt   reversals in the current sequence, saturating at 15
//   peak       level at the most recent rising-to-falling reversal
//   seq_done   1-cycle pulse when the bar returns to level 0
//   done_turns turn_cnt captured at seq_done
//   err_thermo sticky: non-thermometer code seen
//   err_jump   sticky: illegal level step seen
module led_bar_monitor #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned LW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] led_in,
    input  logic             clr,
    output logic [LW-1:0]    level,
    output logic [1:0]       dir,
    output logic             turn,
    output logic [3:0]       turn_cnt,
    output logic [LW-1:0]    peak,
    output logic             seq_done,
    output logic [3:0]       done_turns,
    output logic             err_thermo,
    output logic             err_jump
);

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall
    } state_e;

    localparam logic [1:0] DirIdle = 2'b00;
    localparam logic [1:0] DirRise = 2'b01;
    localparam logic [1:0] DirFall = 2'b10;

    state_e           state;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_inc;
    logic [LW-1:0]    new_level;
    logic [LW-1:0]    cur_plus;
    logic [LW-1:0]    cur_minus;
    logic             code_ok;
    logic             changed;
    logic             step_up;
    logic             step_down;
    logic             thermo_hit;
    logic             jump_hit;

    // For a legal code the popcount equals the thermometer level.
    always_comb begin
        new_level = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_level = new_level + LW'(led_q[i]);
        end
    end

    // 2^k-1 has no bit in common with its successor; all-ones wraps to 0.
    assign led_inc    = led_q + WIDTH'(1);
    assign code_ok    = ~|(led_q & led_inc);
    assign thermo_hit = ~code_ok;

    assign cur_plus  = level + LW'(1);
    assign cur_minus = level - LW'(1);
    assign changed   = code_ok && (new_level != level);
    assign step_up   = (new_level == cur_plus);
    // A drop to 0 ends the sequence and is never treated as a reversal.
    assign step_down = (new_level == cur_minus) && (new_level != '0);

    always_comb begin
        jump_hit = 1'b0;
        if (changed) begin
            if (state == StIdle) begin
                jump_hit = (new_level > LW'(1));
            end else begin
                jump_hit = (new_level != '0) && !step_up && !step_down;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            led_q      <= '0;
            level      <= '0;
            dir        <= DirIdle;
            turn       <= 1'b0;
            turn_cnt   <= '0;
            peak       <= '0;
            seq_done   <= 1'b0;
            done_turns <= '0;
            err_thermo <= 1'b0;
            err_jump   <= 1'b0;
        end else begin
            led_q    <= led_in;
            turn     <= 1'b0;
            seq_done <= 1'b0;

            // Detection wins over a same-cycle clear.
            err_thermo <= (err_thermo & ~clr) | thermo_hit;
            err_jump   <= (err_jump & ~clr) | jump_hit;

            // A peak captured this cycle overrides the clear below.
            if (clr) begin
                peak <= '0;
            end

            if (changed) begin
                level <= new_level;
                unique case (state)
                    StIdle: begin
                        state    <= StRise;
                        dir      <= DirRise;
                        turn_cnt <= '0;
                    end
                    StRise: begin
                        if (new_level == '0) begin
                            state      <= StIdle;
                            dir        <= DirIdle;
                            seq_done   <= 1'b1;
                            done_turns <= turn_cnt;
                        end else if (step_down) begin
                            state <= StFall;
                            dir   <= DirFall;
                            turn  <= 1'b1;
                            peak  <= level;
                            if (turn_cnt != 4'hF) begin
                                turn_cnt <= turn_cnt + 4'd1;
                            end
                        end
                    end
                    StFall: begin
                        if (new_level == '0) begin
                            state      <= StIdle;
                            dir        <= DirIdle;
                            seq_done   <= 1'b1;
                            done_turns <= turn_cnt;
                        end else if (step_up) begin
                            state <= StRise;
                            dir   <= DirRise;
                            turn  <= 1'b1;
                            if (turn_cnt != 4'hF) begin
                                turn_cnt <= turn_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                        dir   <= DirIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor
//   Self-checking bench for led_bar_monitor. A behavioural model tracks the
//   bar as a signed direction and integer level and is stepped one cycle
//   behind the bus (the input register), then compared with the DUT.
module tb_led_bar_monitor;

    logic        clk;
    logic        rst_n;
    logic [15:0] led_in;
    logic        clr;
    logic [4:0]  level;
    logic [1:0]  dir;
    logic        turn;
    logic [3:0]  turn_cnt;
    logic [4:0]  peak;
    logic        seq_done;
    logic [3:0]  done_turns;
    logic        err_thermo;
    logic        err_jump;

    led_bar_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_in    (led_in),
        .clr       (clr),
        .level     (level),
        .dir       (dir),
        .turn      (turn),
        .turn_cnt  (turn_cnt),
        .peak      (peak),
        .seq_done  (seq_done),
        .done_turns(done_turns),
        .err_thermo(err_thermo),
        .err_jump  (err_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Model state
    int          m_level, m_dir, m_cnt, m_peak, m_done;
    bit          m_turn, m_seq, m_et, m_ej;
    logic [15:0] pending;

    // Level of a thermometer code, or -1 when the code is not 2^k-1.
    function automatic int code_level(input logic [15:0] v);
        for (int k = 0; k <= 16; k++) begin
            if ({1'b0, v} == (17'(1) << k) - 17'(1)) return k;
        end
        return -1;
    endfunction

    function automatic logic [15:0] code_of(input int k);
        logic [16:0] t;
        t = (17'(1) << k) - 17'(1);
        return t[15:0];
    endfunction

    function automatic logic [23:0] dut_vec();
        return {level, dir, turn, turn_cnt, peak, seq_done, done_turns, err_thermo, err_jump};
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [1:0] d;
        d = (m_dir == 1) ? 2'b01 : (m_dir == -1) ? 2'b10 : 2'b00;
        return {5'(m_level), d, m_turn, 4'(m_cnt), 5'(m_peak), m_seq, 4'(m_done), m_et, m_ej};
    endfunction

    task automatic model_reset();
        m_level = 0; m_dir = 0; m_cnt = 0; m_peak = 0; m_done = 0;
        m_turn = 0; m_seq = 0; m_et = 0; m_ej = 0;
        pending = '0;
    endtask

    task automatic model_step(input logic [15:0] code, input bit c);
        int n;
        bit et, ej, pk_set;
        n = code_level(code);
        et = 0; ej = 0; pk_set = 0;
        m_turn = 0;
        m_seq = 0;
        if (n < 0) begin
            et = 1;
        end else if (n != m_level) begin
            if (m_dir == 0) begin
                m_dir = 1;
                m_cnt = 0;
                if (n > 1) ej = 1;
            end else if (n == 0) begin
                m_dir = 0;
                m_seq = 1;
                m_done = m_cnt;
            end else if (n == m_level - m_dir) begin
                if (m_dir == 1) begin
                    m_peak = m_level;
                    pk_set = 1;
                end
                m_dir = -m_dir;
                m_turn = 1;
                if (m_cnt < 15) m_cnt++;
            end else if (n != m_level + m_dir) begin
                ej = 1;
            end
            m_level = n;
        end
        if (c) begin
            m_et = 0;
            m_ej = 0;
            if (!pk_set) m_peak = 0;
        end
        m_et = m_et | et;
        m_ej = m_ej | ej;
    endtask

    // Called at posedge+1: drive inputs, advance one edge, update model.
    task automatic drive(input logic [15:0] v, input bit c);
        led_in = v;
        clr = c;
        @(posedge clk);
        model_step(pending, c);
        pending = v;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        led_in = '0;
        clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        led_in = '0;
        clr = 1'b0;
        model_reset();
        #12;
        n_total++;
        if (dut_vec() !== 24'h0) $display("FAIL reset_vals got %h want %h", dut_vec(), 24'h0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(16'h0000, 1'b0);
            n_total++;
            if (dut_vec() !== 24'h0) $display("FAIL idle_hold got %h want %h", dut_vec(), 24'h0);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(code_of(k), 1'b0);
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL ramp_up got %h want %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        drive(code_of(15), 1'b0);
        n_total++;
        if (level !== 5'd16 || dir !== 2'b01)
            $display("FAIL ramp_top got lvl=%0d dir=%b want lvl=16 dir=01", level, dir);
        else n_pass++;
        drive(code_of(14), 1'b0);
        n_total++;
        if (turn !== 1'b1 || turn_cnt !== 4'd1 || peak !== 5'd16 || dir !== 2'b10)
            $display("FAIL ramp_turn got turn=%b cnt=%0d peak=%0d dir=%b want 1/1/16/10",
                     turn, turn_cnt, peak, dir);
        else n_pass++;
        for (int k = 13; k >= 5; k--) begin
            drive(code_of(k), 1'b0);
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL ramp_dn got %h want %h", dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_flasher();
        int path[$];
        int got_done[$];
        do_reset();
        for (int k = 1; k <= 16; k++) path.push_back(k);
        for (int k = 15; k >= 5; k--) path.push_back(k);
        for (int k = 6; k <= 11; k++) path.push_back(k);
        for (int k = 10; k >= 0; k--) path.push_back(k);
        for (int k = 1; k <= 6; k++) path.push_back(k);
        for (int k = 5; k >= 0; k--) path.push_back(k);
        path.push_back(0);
        path.push_back(0);
        foreach (path[i]) begin
            drive(code_of(path[i]), 1'b0);
            if (seq_done === 1'b1) got_done.push_back(int'(done_turns));
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL flasher got %h want %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (got_done.size() != 2 || got_done[0] != 3 || got_done[1] != 1)
            $display("FAIL flasher_done got n=%0d want 2 sequences with 3,1 turns", got_done.size());
        else n_pass++;
        n_total++;
        if (err_thermo !== 1'b0 || err_jump !== 1'b0)
            $display("FAIL flasher_err got %b%b want 00", err_thermo, err_jump);
        else n_pass++;
    endtask

    task automatic test_thermo_and_jump();
        do_reset();
        drive(16'h0001, 1'b0);
        drive(16'h0003, 1'b0);
        drive(16'h0007, 1'b0);
        drive(16'h0005, 1'b0);
        drive(16'h000F, 1'b0);
        n_total++;
        if (err_thermo !== 1'b1 || level !== 5'd3)
            $display("FAIL thermo_inject got et=%b lvl=%0d want et=1 lvl=3", err_thermo, level);
        else n_pass++;
        drive(16'h01FF, 1'b0);
        n_total++;
        if (level !== 5'd4 || err_jump !== 1'b0 || dut_vec() !== exp_vec())
            $display("FAIL thermo_recover got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
        drive(16'h01FF, 1'b0);
        n_total++;
        if (level !== 5'd9 || err_jump !== 1'b1 || dir !== 2'b01)
            $display("FAIL jump_up got lvl=%0d ej=%b dir=%b want 9/1/01", level, err_jump, dir);
        else n_pass++;
        drive(16'h0007, 1'b0);
        drive(16'h0007, 1'b1);
        n_total++;
        if (err_jump !== 1'b1 || level !== 5'd3 || err_thermo !== 1'b0)
            $display("FAIL jump_clr_same got ej=%b lvl=%0d et=%b want 1/3/0",
                     err_jump, level, err_thermo);
        else n_pass++;
        drive(16'h0007, 1'b1);
        n_total++;
        if (err_jump !== 1'b0 || peak !== 5'd0 || dut_vec() !== exp_vec())
            $display("FAIL clr_alone got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_saturate();
        int turns;
        turns = 0;
        do_reset();
        drive(code_of(1), 1'b0);
        drive(code_of(2), 1'b0);
        drive(code_of(3), 1'b0);
        for (int i = 0; i < 41; i++) begin
            drive(code_of((i % 2 == 0) ? 2 : 3), 1'b0);
            if (turn === 1'b1) turns++;
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL saturate got %h want %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (turn_cnt !== 4'd15 || turns != 40)
            $display("FAIL saturate_end got cnt=%0d turns=%0d want 15/40", turn_cnt, turns);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 10; k++) drive(code_of(k), 1'b0);
        for (int k = 9; k >= 7; k--) drive(code_of(k), 1'b0);
        drive(code_of(7), 1'b0);
        n_total++;
        if (level !== 5'd7 || dir !== 2'b10)
            $display("FAIL mid_pre got lvl=%0d dir=%b want 7/10", level, dir);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (dut_vec() !== 24'h0) $display("FAIL mid_async got %h want %h", dut_vec(), 24'h0);
        else n_pass++;
        led_in = 16'h003F;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(16'h003F, 1'b0);
        drive(16'h003F, 1'b0);
        n_total++;
        if (level !== 5'd6 || dir !== 2'b01 || err_jump !== 1'b1 || dut_vec() !== exp_vec())
            $display("FAIL mid_release got %h want %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        int lvl, r, n;
        logic [15:0] v;
        bit c;
        do_reset();
        lvl = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if (lvl == 0) lvl = 1;
                else if (lvl == 16) lvl = 15;
                else lvl = ($urandom_range(0, 1) == 1) ? lvl + 1 : lvl - 1;
                v = code_of(lvl);
            end else if (r < 80) begin
                v = code_of(lvl);
            end else if (r < 87) begin
                lvl = $urandom_range(0, 16);
                v = code_of(lvl);
            end else if (r < 94) begin
                v = 16'($urandom);
                n = code_level(v);
                if (n >= 0) v = 16'h0005;
            end else begin
                lvl = 0;
                v = 16'h0000;
            end
            c = ($urandom_range(0, 15) == 0);
            drive(v, c);
            n_total++;
            if (dut_vec() !== exp_vec()) $display("FAIL random i=%0d got %h want %h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_ramp();
        test_flasher();
        test_thermo_and_jump();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
